tcb_dense_seq: RTL and testbench
================================

# tcb_dense_seq

Parametrised, time-multiplexed ternary-coded dense layer for the CIFAR-10 TCB network family. It replaces the fixed-size, fully unrolled per-layer modules with one configurable engine. The engine accepts a full input vector under a valid/ready handshake and accumulates one input per cycle into N_OUT parallel accumulators. It then optionally applies ReLU and an arg-max scan, and holds the result until the consumer accepts it. All weights and biases are small signed multiples of one constant SCALE, realised by shift-add only. No multipliers are used.

## Interface
- N_IN, 16: inputs per vector.
- N_OUT, 10: neurons (outputs).
- IN_W, 20: signed input element width.
- ACC_W, 29: signed accumulator/output element width.
- SCALE, 59: positive weight/bias quantum. Realised as a constant shift-add.
- WEIGHTS, 0: packed 3-bit signed codes k ∈ [-3,3]. Code for neuron o, input i sits at bits [(o*N_IN+i)*3 +: 3].
- BIASES, 0: packed 3-bit signed codes. Code for neuron o sits at bits [o*3 +: 3].
- RELU, 0: 1 = clamp negative outputs to 0.
- ARGMAX, 0: 1 = run the arg-max scan before output.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: reset, synchronous, active-high.
- in_valid  in  1: input vector valid.
- in_ready  out  1: block can accept a vector.
- in_data  in  N_IN*IN_W: element i sits at [i*IN_W +: IN_W], two's complement.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- out_data  out  N_OUT*ACC_W: neuron o sits at [o*ACC_W +: ACC_W].
- out_class  out  max(1,$clog2(N_OUT)): arg-max index. Held at 0 when ARGMAX=0.

## Operation
- FSM states: IDLE, ACC, SCAN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, in_data is registered into an input buffer.
  - Each acc[o] is loaded with BIASES[o]*SCALE, sign-extended to ACC_W.
  - Input index i=0. Next state is ACC.
- ACC: each cycle, x = sext(buf[i]) to ACC_W and xs = x*SCALE (shift-add).
  - Every acc[o] += k[o][i]*xs, where k·xs ∈ {0, ±xs, ±2xs, ±3xs}.
  - 2xs is formed as xs<<1. 3xs is formed as xs+(xs<<1).
  - i increments. After i=N_IN-1, the next state is SCAN if ARGMAX=1, otherwise DONE.
- SCAN: N_OUT cycles, index j=0..N_OUT-1.
  - Keeps a running best value and index over the post-ReLU values.
  - Replaces the best only on a strictly greater value, so ties resolve to the lowest index. Next state is DONE.
- DONE: out_valid=1. out_data holds acc, or max(acc,0) per element when RELU=1. out_class holds the best index.
  - On out_ready, go to IDLE.
- Arithmetic:
  - All sums are two's complement, modulo 2^ACC_W.
  - Overflow wraps silently. No saturation, no flag.
  - Comparisons are signed ACC_W.
- in_data is ignored outside IDLE. in_valid may stay high with no effect.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_class=0, state=IDLE, accumulators=0.
  - in_ready rises on the first edge after rst deasserts.
- Accept edge E0 (in_valid&in_ready). in_ready=0 from E0 until the return to IDLE.
- ACC updates occur on edges E1..E_N_IN.
- out_valid rises after edge E_N_IN when ARGMAX=0, or after edge E_(N_IN+N_OUT) when ARGMAX=1.
- out_valid, out_data and out_class are registered. They are stable while out_valid=1 and out_ready=0.
- The handshake edge with out_valid&out_ready clears out_valid and returns the FSM to IDLE. in_ready=1 in the next cycle.
- Minimum accept-to-accept spacing is N_IN+2 cycles (ARGMAX=0) or N_IN+N_OUT+2 cycles (ARGMAX=1).
- Reset mid-operation (any state) aborts the operation. All outputs return to their reset values on that edge, and no result is emitted.

## Structure
- Package tcb_pkg holds:
  - the weight-code typedef (logic signed [2:0]);
  - localparams for the code range;
  - function code_at(packed, idx) for extracting codes.
- Sub-module tcb_scale_mul (IN_W, ACC_W, SCALE) computes xs = x*SCALE by constant shift-add. One instance is shared by all neurons.
- The per-neuron k·xs select is a 7-way mux inside the top module.

## Test plan
- Test config: N_IN=4, N_OUT=3, IN_W=20, ACC_W=29, SCALE=59.
- All weights 0, bias code -3, RELU=0 -> every out_data element = -177 (0x1FFFFF4F), out_valid 4 cycles after accept.
- in=[0,10,0,0], k[0][1]=+2, other weights 0, biases 0 -> neuron 0 = 1180, others 0.
- Same as the previous case with k[0][1]=-2 and RELU=1 -> neuron 0 = 0, not -1180.
- ARGMAX=1, results [118,177,177] -> out_class=1 (tie to lowest index), out_valid 7 cycles after accept.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Release -> in_ready=1 in the next cycle.
- Wrap: N_IN=16, all in=524287, all k=+3, bias 0 -> every output = -125831952 (modulo 2^29).
- Reset: assert rst at E2 -> out_valid never rises and all outputs are 0. A fresh vector after reset gives the correct result.

Source files
------------

// File: rtl/tcb_pkg.sv
// rtl/tcb_pkg.sv - shared types, code range and code extraction for the TCB dense engine
package tcb_pkg;

  typedef logic signed [2:0] code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } tcb_state_t;

  localparam int CODE_W     = 3;
  localparam int CODE_MIN   = -3;
  localparam int CODE_MAX   = 3;
  localparam int MAX_CODES  = 1024;
  localparam int CODE_VEC_W = CODE_W * MAX_CODES;

  function automatic code_t code_at(input logic [CODE_VEC_W-1:0] packed_codes, input int idx);
    return code_t'(packed_codes[idx*CODE_W +: CODE_W]);
  endfunction

endpackage

// File: rtl/tcb_scale_mul.sv
// rtl/tcb_scale_mul.sv - constant multiply x*SCALE built from shifted adds of the sign-extended input
module tcb_scale_mul #(
  parameter int IN_W  = 20,
  parameter int ACC_W = 29,
  parameter int SCALE = 59
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [ACC_W-1:0] xs
);

  localparam logic [31:0] SCALE_BITS = 32'(SCALE);

  logic signed [ACC_W-1:0] x_ext;

  assign x_ext = {{(ACC_W-IN_W){x[IN_W-1]}}, x};

  // SCALE is a constant, so only the set bits survive as adders
  always_comb begin
    xs = '0;
    for (int b = 0; b < 32; b++) begin
      if (SCALE_BITS[b]) xs = xs + (x_ext <<< b);
    end
  end

endmodule

// File: rtl/tcb_dense_seq.sv
// rtl/tcb_dense_seq.sv - time-multiplexed ternary-coded dense layer with optional ReLU and arg-max
module tcb_dense_seq
  import tcb_pkg::*;
#(
  parameter int                        N_IN    = 16,
  parameter int                        N_OUT   = 10,
  parameter int                        IN_W    = 20,
  parameter int                        ACC_W   = 29,
  parameter int                        SCALE   = 59,
  parameter logic [N_OUT*N_IN*3-1:0]   WEIGHTS = '0,
  parameter logic [N_OUT*3-1:0]        BIASES  = '0,
  parameter bit                        RELU    = 1'b0,
  parameter bit                        ARGMAX  = 1'b0,
  localparam int                       CLS_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_W-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*ACC_W-1:0]   out_data,
  output logic [CLS_W-1:0]         out_class
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CODE_VEC_W-1:0] W_EXT   = CODE_VEC_W'(WEIGHTS);
  localparam logic [CODE_VEC_W-1:0] B_EXT   = CODE_VEC_W'(BIASES);
  localparam logic signed [ACC_W-1:0] SCALE_A = ACC_W'(SCALE);

  tcb_state_t              state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [N_OUT*ACC_W-1:0]  out_data_q, out_data_d;
  logic [CLS_W-1:0]        out_class_q, out_class_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CLS_W-1:0]        scan_q, scan_d;
  logic signed [ACC_W-1:0] best_val_q, best_val_d;
  logic [CLS_W-1:0]        best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];
  logic signed [IN_W-1:0]  in_buf_q [N_IN];
  logic signed [IN_W-1:0]  in_buf_d [N_IN];
  logic signed [ACC_W-1:0] xs;
  logic signed [ACC_W-1:0] cand;

  // 7-way select of k*v; codes outside [-3,3] contribute nothing
  function automatic logic signed [ACC_W-1:0] k_times(input code_t k,
                                                      input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] v2;
    logic signed [ACC_W-1:0] v3;
    v2 = v <<< 1;
    v3 = v + v2;
    if (int'(k) < CODE_MIN || int'(k) > CODE_MAX) return '0;
    case (k)
      3'b001:  return v;
      3'b010:  return v2;
      3'b011:  return v3;
      3'b111:  return -v;
      3'b110:  return -v2;
      3'b101:  return -v3;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] relu_f(input logic signed [ACC_W-1:0] v);
    return (RELU && v[ACC_W-1]) ? '0 : v;
  endfunction

  tcb_scale_mul #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .SCALE (SCALE)
  ) u_scale_mul (
    .x  (in_buf_q[idx_q]),
    .xs (xs)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scan_d      = scan_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    acc_d       = acc_q;
    in_buf_d    = in_buf_q;
    out_data_d  = out_data_q;
    out_class_d = out_class_q;
    cand        = relu_f(acc_q[scan_q]);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < N_IN; i++) in_buf_d[i] = in_data[i*IN_W +: IN_W];
          for (int o = 0; o < N_OUT; o++) acc_d[o] = k_times(code_at(B_EXT, o), SCALE_A);
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        for (int o = 0; o < N_OUT; o++) begin
          acc_d[o] = acc_q[o] + k_times(code_at(W_EXT, o*N_IN + int'(idx_q)), xs);
        end
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(N_IN-1)) begin
          idx_d = '0;
          if (ARGMAX) begin
            scan_d  = '0;
            state_d = SCAN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        // strict greater-than keeps the lowest index on ties
        if (scan_q == '0 || cand > best_val_q) begin
          best_val_d = cand;
          best_idx_d = scan_q;
        end
        scan_d = CLS_W'(scan_q + 1'b1);
        if (scan_q == CLS_W'(N_OUT-1)) begin
          scan_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != DONE && state_d == DONE) begin
      for (int o = 0; o < N_OUT; o++) out_data_d[o*ACC_W +: ACC_W] = relu_f(acc_d[o]);
      out_class_d = ARGMAX ? best_idx_d : '0;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_class_q <= '0;
      idx_q       <= '0;
      scan_q      <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
      for (int i = 0; i < N_IN; i++) in_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
      idx_q       <= idx_d;
      scan_q      <= scan_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      acc_q       <= acc_d;
      in_buf_q    <= in_buf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_class = out_class_q;

endmodule

// File: tb/tb_tcb_dense_seq.sv
// tb/tb_tcb_dense_seq.sv - directed checks of tcb_dense_seq across five parameter configurations
module tb_tcb_dense_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   vld;
  logic [4:0]   ordy;
  logic [4:0]   ir;
  logic [4:0]   ov;
  logic [86:0]  od [5];
  logic [1:0]   oc [5];
  logic [79:0]  din4;
  logic [319:0] din16;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           lat;
  logic         seen;
  logic [86:0]  exp_d;

  localparam logic [28:0] NEG177 = 29'h1FFFFF4F;
  localparam logic [28:0] WRAPV  = 29'd411038960;

  always #5 clk = ~clk;

  tcb_dense_seq #(.N_IN(4), .N_OUT(3), .WEIGHTS(36'h0), .BIASES(9'b101_101_101)) dut_a (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ir[0]), .in_data(din4),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_class(oc[0]));

  tcb_dense_seq #(.N_IN(4), .N_OUT(3), .WEIGHTS(36'h10), .BIASES(9'h0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ir[1]), .in_data(din4),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_class(oc[1]));

  tcb_dense_seq #(.N_IN(4), .N_OUT(3), .WEIGHTS(36'h30), .BIASES(9'h0), .RELU(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ir[2]), .in_data(din4),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_class(oc[2]));

  tcb_dense_seq #(.N_IN(4), .N_OUT(3), .WEIGHTS(36'h0), .BIASES(9'd218), .ARGMAX(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(ir[3]), .in_data(din4),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_class(oc[3]));

  tcb_dense_seq #(.N_IN(16), .N_OUT(3), .WEIGHTS({48{3'b011}}), .BIASES(9'h0)) dut_e (
    .clk(clk), .rst(rst), .in_valid(vld[4]), .in_ready(ir[4]), .in_data(din16),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od[4]), .out_class(oc[4]));

  task automatic chk(input string tag, input logic [86:0] obs, input logic [86:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // accept one vector on instance n, return cycles from accept edge to out_valid
  task automatic send(input int n, output int latency);
    int w;
    w = 0;
    while (!ir[n] && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    vld[n] = 1'b1;
    @(posedge clk); #1;
    vld[n] = 1'b0;
    latency = 0;
    while (!ov[n] && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    vld   = '0;
    ordy  = 5'b10111;
    din4  = '0;
    din16 = {16{20'd524287}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  87'(ir), 87'(0));
    chk("rst_out_valid", 87'(ov), 87'(0));
    chk("rst_out_data",  od[0] | od[3] | od[4], 87'(0));
    chk("rst_out_class", 87'(oc[3]), 87'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 87'(ir), 87'(5'h1f));

    din4 = {4{20'd7}};
    send(0, lat);
    chk("bias_only_latency", 87'(lat), 87'(4));
    chk("bias_only_data", od[0], {NEG177, NEG177, NEG177});
    chk("bias_only_class", 87'(oc[0]), 87'(0));

    din4 = {20'd0, 20'd0, 20'd10, 20'd0};
    send(1, lat);
    chk("k_pos2_data", od[1], {29'd0, 29'd0, 29'd1180});
    @(posedge clk); #1;
    chk("k_pos2_ready_back", 87'(ir[1]), 87'(1));

    send(2, lat);
    chk("k_neg2_relu_data", od[2], 87'(0));

    send(3, lat);
    exp_d = {29'd177, 29'd177, 29'd118};
    chk("argmax_latency", 87'(lat), 87'(7));
    chk("argmax_data", od[3], exp_d);
    chk("argmax_class_tie", 87'(oc[3]), 87'(1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_stable", {ov[3], ir[3], oc[3], od[3][82:0]}, {1'b1, 1'b0, 2'd1, exp_d[82:0]});
    end
    ordy[3] = 1'b1;
    @(posedge clk); #1;
    chk("release_valid_low", 87'(ov[3]), 87'(0));
    chk("release_ready_high", 87'(ir[3]), 87'(1));

    send(4, lat);
    chk("wrap_latency", 87'(lat), 87'(16));
    chk("wrap_data", od[4], {WRAPV, WRAPV, WRAPV});

    din4 = {20'd0, 20'd0, 20'd10, 20'd0};
    vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 87'(ov), 87'(0));
    chk("abort_ready", 87'(ir), 87'(0));
    chk("abort_data", od[1], 87'(0));
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      seen = seen | ov[1];
    end
    chk("abort_no_result", 87'(seen), 87'(0));
    send(1, lat);
    chk("after_abort_latency", 87'(lat), 87'(4));
    chk("after_abort_data", od[1], {29'd0, 29'd0, 29'd1180});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
